// File: rtl/sccb_target.sv
// sccb_target: SCCB (I2C-style) write responder with a 256x8 register file.
// Decodes ID / subaddress / value writes from SIOC/SIOD, acknowledges them,
// stores each value and reports every committed write to the host side.
// Optional feature: define SCCB_READ_EN to answer the read ID (DEVICE_ID|1)
// by shifting out mem[PTR]. Without it the read ID is treated as a mismatch
// and no read logic exists.
module sccb_target #(
  parameter logic [7:0] DEVICE_ID = 8'h42
) (
  input  logic       GLOBAL_CLK,
  input  logic       RESET,
  input  logic       SIOC,
  inout  wire        SIOD,
  output logic       WR_STROBE,
  output logic [7:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  input  logic [7:0] RD_ADDR,
  output logic [7:0] RD_DATA,
  output logic       BUSY
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ID        = 4'd1,
    ST_ID_ACK    = 4'd2,
    ST_SUB       = 4'd3,
    ST_SUB_ACK   = 4'd4,
    ST_DATA      = 4'd5,
    ST_DATA_ACK  = 4'd6,
    ST_WAIT_STOP = 4'd7
`ifdef SCCB_READ_EN
    ,
    ST_RD_BYTE   = 4'd8,
    ST_RD_NA     = 4'd9
`endif
  } state_t;

  // Bus conditioning: two synchronizer flops plus one history flop per line.
  logic scl_meta, scl_sync, scl_hist;
  logic sda_meta, sda_sync, sda_hist;

  // FSM state and datapath registers.
  state_t     state, state_nx;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic [6:0] shift, shift_nx;      // the 7 most recent bits; the 8th is live
  logic [7:0] ptr, ptr_nx;
  logic       oe, oe_nx;            // 1 = pull SIOD low
  logic       commit;
  logic [7:0] byte_in;

`ifdef SCCB_READ_EN
  logic       rd_mode, rd_mode_nx;
  logic [7:0] ptr_data;
`endif

  logic [7:0] mem [0:255];

  logic scl_rise, scl_fall, start_det, stop_det;

  // Open-drain pad: only ever drive a zero.
  assign SIOD = oe ? 1'b0 : 1'bz;

  assign scl_rise  = scl_sync & ~scl_hist;
  assign scl_fall  = ~scl_sync & scl_hist;
  // START/STOP need SIOC stably high on both sides of the SIOD edge.
  assign start_det = scl_sync & scl_hist & sda_hist & ~sda_sync;
  assign stop_det  = scl_sync & scl_hist & ~sda_hist & sda_sync;
  assign byte_in   = {shift, sda_sync};

  // Free-running synchronizers; kept out of reset so that no false bus
  // edge appears when reset is released in the middle of a transfer.
  always_ff @(posedge GLOBAL_CLK) begin
    scl_meta <= SIOC;
    scl_sync <= scl_meta;
    scl_hist <= scl_sync;
    sda_meta <= SIOD;
    sda_sync <= sda_meta;
    sda_hist <= sda_sync;
  end

  // Next-state and datapath decode; bus START/STOP override every state.
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift;
    ptr_nx     = ptr;
    oe_nx      = oe;
    commit     = 1'b0;
`ifdef SCCB_READ_EN
    rd_mode_nx = rd_mode;
`endif
    if (stop_det) begin
      state_nx   = ST_IDLE;
      oe_nx      = 1'b0;
      bit_cnt_nx = 3'd0;
    end else if (start_det) begin
      state_nx   = ST_ID;
      oe_nx      = 1'b0;
      bit_cnt_nx = 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nx = ST_IDLE;
        end
        ST_ID: begin
          if (scl_rise) begin
            shift_nx   = byte_in[6:0];
            bit_cnt_nx = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (byte_in == DEVICE_ID) begin
                state_nx = ST_ID_ACK;
`ifdef SCCB_READ_EN
                rd_mode_nx = 1'b0;
              end else if (byte_in == (DEVICE_ID | 8'h01)) begin
                state_nx   = ST_ID_ACK;
                rd_mode_nx = 1'b1;
`endif
              end else begin
                state_nx = ST_WAIT_STOP;
              end
            end else begin
              state_nx = ST_ID;
            end
          end else begin
            shift_nx = shift;
          end
        end
        ST_ID_ACK: begin
          if (scl_fall) begin
            if (!oe) begin
              oe_nx = 1'b1;
            end else begin
              bit_cnt_nx = 3'd0;
`ifdef SCCB_READ_EN
              if (rd_mode) begin
                // The fall that ends the ACK also presents the first bit.
                state_nx = ST_RD_BYTE;
                shift_nx = ptr_data[6:0];
                oe_nx    = ~ptr_data[7];
              end else begin
                state_nx = ST_SUB;
                oe_nx    = 1'b0;
              end
`else
              state_nx = ST_SUB;
              oe_nx    = 1'b0;
`endif
            end
          end else begin
            oe_nx = oe;
          end
        end
        ST_SUB: begin
          if (scl_rise) begin
            shift_nx   = byte_in[6:0];
            bit_cnt_nx = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr_nx   = byte_in;
              state_nx = ST_SUB_ACK;
            end else begin
              state_nx = ST_SUB;
            end
          end else begin
            shift_nx = shift;
          end
        end
        ST_SUB_ACK: begin
          if (scl_fall) begin
            if (!oe) begin
              oe_nx = 1'b1;
            end else begin
              oe_nx      = 1'b0;
              bit_cnt_nx = 3'd0;
              state_nx   = ST_DATA;
            end
          end else begin
            oe_nx = oe;
          end
        end
        ST_DATA: begin
          if (scl_rise) begin
            shift_nx   = byte_in[6:0];
            bit_cnt_nx = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              commit   = 1'b1;
              state_nx = ST_DATA_ACK;
            end else begin
              state_nx = ST_DATA;
            end
          end else begin
            shift_nx = shift;
          end
        end
        ST_DATA_ACK: begin
          if (scl_fall) begin
            if (!oe) begin
              oe_nx = 1'b1;
            end else begin
              oe_nx      = 1'b0;
              bit_cnt_nx = 3'd0;
              state_nx   = ST_WAIT_STOP;
            end
          end else begin
            oe_nx = oe;
          end
        end
        ST_WAIT_STOP: begin
          state_nx = ST_WAIT_STOP;
        end
`ifdef SCCB_READ_EN
        ST_RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              oe_nx      = 1'b0;
              bit_cnt_nx = 3'd0;
              state_nx   = ST_RD_NA;
            end else begin
              bit_cnt_nx = bit_cnt + 3'd1;
              oe_nx      = ~shift[6];
              shift_nx   = {shift[5:0], 1'b0};
            end
          end else begin
            oe_nx = oe;
          end
        end
        ST_RD_NA: begin
          // The initiator's NA bit is not inspected.
          if (scl_rise) begin
            state_nx = ST_WAIT_STOP;
          end else begin
            state_nx = ST_RD_NA;
          end
        end
`endif
        default: begin
          state_nx   = ST_IDLE;
          oe_nx      = 1'b0;
          bit_cnt_nx = 3'd0;
        end
      endcase
    end
  end

  // FSM state and datapath register update.
  always_ff @(posedge GLOBAL_CLK) begin
    if (RESET) begin
      state   <= ST_IDLE;
      bit_cnt <= 3'd0;
      shift   <= 7'd0;
      ptr     <= 8'd0;
      oe      <= 1'b0;
`ifdef SCCB_READ_EN
      rd_mode <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      shift   <= shift_nx;
      ptr     <= ptr_nx;
      oe      <= oe_nx;
`ifdef SCCB_READ_EN
      rd_mode <= rd_mode_nx;
`endif
    end
  end

  // Host-side write report and busy flag.
  always_ff @(posedge GLOBAL_CLK) begin
    if (RESET) begin
      WR_STROBE <= 1'b0;
      WR_ADDR   <= 8'd0;
      WR_DATA   <= 8'd0;
      BUSY      <= 1'b0;
    end else begin
      WR_STROBE <= commit;
      BUSY      <= (state_nx != ST_IDLE);
      if (commit) begin
        WR_ADDR <= ptr;
        WR_DATA <= byte_in;
      end
    end
  end

  // Register file write, taken from the strobe cycle so that a host read
  // of the same address in that cycle still returns the previous value.
  always_ff @(posedge GLOBAL_CLK) begin
    if (WR_STROBE) begin
      mem[WR_ADDR] <= WR_DATA;
    end
  end

  // Registered host read port.
  always_ff @(posedge GLOBAL_CLK) begin
    if (RESET) begin
      RD_DATA <= 8'd0;
    end else begin
      RD_DATA <= mem[RD_ADDR];
    end
  end

`ifdef SCCB_READ_EN
  // Second read port tracking mem[PTR] for the serial read-out.
  always_ff @(posedge GLOBAL_CLK) begin
    ptr_data <= mem[ptr];
  end
`endif

endmodule

// File: tb/tb_sccb_target.sv
// Self-checking bench for sccb_target: bit-bangs an SCCB initiator on an
// open-drain bus and compares acks, write reports and register file
// contents against a transaction-level model.
module tb_sccb_target;

  localparam logic [7:0] DEV_ID = 8'h42;
  localparam int Q = 5;              // quarter SIOC period in clocks

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       sda_drv;               // 1 = initiator releases SIOD
  logic [7:0] rd_addr;
  logic       wr_strobe;
  logic [7:0] wr_addr, wr_data, rd_data;
  logic       busy;
  wire        siod;

  pullup (siod);
  assign siod = sda_drv ? 1'bz : 1'b0;

  always #5 clk = ~clk;

  sccb_target #(.DEVICE_ID(DEV_ID)) dut (
    .GLOBAL_CLK(clk), .RESET(rst), .SIOC(scl), .SIOD(siod),
    .WR_STROBE(wr_strobe), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .RD_ADDR(rd_addr), .RD_DATA(rd_data), .BUSY(busy)
  );

  int checks = 0;
  int errors = 0;

  // model state
  logic [7:0] mref  [256];
  bit         known [256];
  logic [7:0] m_wr_addr = 8'h00;
  logic [7:0] m_wr_data = 8'h00;

  // monitors
  int         stb_cnt   = 0;
  int         drive_cnt = 0;
  logic       stb_d1 = 1'b0, stb_d2 = 1'b0;
  logic [7:0] rd_old = 8'h00, rd_new = 8'h00;

  always @(negedge clk) begin
    stb_d1 <= wr_strobe;
    stb_d2 <= stb_d1;
    if (wr_strobe === 1'b1) stb_cnt <= stb_cnt + 1;
    if (stb_d1) rd_old <= rd_data;   // read issued during the strobe cycle
    if (stb_d2) rd_new <= rd_data;   // read issued one cycle later
    if (siod === 1'b0 && sda_drv === 1'b1) drive_cnt <= drive_cnt + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    if (scl == 1'b0) begin
      cyc(Q); sda_drv = 1'b1; cyc(Q); scl = 1'b1; cyc(Q);
    end else begin
      cyc(Q);
    end
    sda_drv = 1'b0; cyc(Q); scl = 1'b0;
  endtask

  task automatic bus_stop();
    cyc(Q); sda_drv = 1'b0; cyc(Q); scl = 1'b1; cyc(Q); sda_drv = 1'b1; cyc(2*Q);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      cyc(Q); sda_drv = b[i]; cyc(Q); scl = 1'b1; cyc(2*Q); scl = 1'b0;
    end
  endtask

  task automatic ack_slot(output bit acked);
    cyc(Q); sda_drv = 1'b1; cyc(Q); scl = 1'b1; cyc(Q);
    acked = (siod === 1'b0);
    cyc(Q); scl = 1'b0;
  endtask

  task automatic read_bits(output logic [7:0] b);
    sda_drv = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      cyc(2*Q); scl = 1'b1; cyc(Q);
      b[i] = (siod !== 1'b0);
      cyc(Q); scl = 1'b0;
    end
  endtask

  // One complete write-style transaction of n bytes, checked against the model.
  task automatic xfer(input logic [7:0] b0, b1, b2, b3, input int n);
    logic [7:0] bytes [4];
    bit acked, exp_ack, match, commit, old_known;
    int stb0;
    logic [7:0] old_val;
    bytes     = '{b0, b1, b2, b3};
    match     = (b0 == DEV_ID);
    commit    = match && (n >= 3);
    old_val   = mref[b1];
    old_known = known[b1];
    stb0      = stb_cnt;
    rd_addr   = b1;
    bus_start();
    for (int k = 0; k < n; k++) begin
      send_bits(bytes[k]);
      ack_slot(acked);
      exp_ack = match && (k < 3);
      checks++;
      if (acked !== exp_ack) begin
        errors++;
        $display("FAIL ack id=%02h byte%0d: got %0d expected %0d", b0, k, acked, exp_ack);
      end
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_mid id=%02h: got %b expected 1", b0, busy);
    end
    bus_stop();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL busy_stop id=%02h: got %b expected 0", b0, busy);
    end
    if (commit) begin
      mref[b1] = b2; known[b1] = 1'b1; m_wr_addr = b1; m_wr_data = b2;
    end
    checks++;
    if ((stb_cnt - stb0) != (commit ? 1 : 0)) begin
      errors++; $display("FAIL strobe_count id=%02h: got %0d expected %0d", b0, stb_cnt - stb0, commit ? 1 : 0);
    end
    checks++;
    if (wr_addr !== m_wr_addr || wr_data !== m_wr_data) begin
      errors++; $display("FAIL wr_report: got %02h/%02h expected %02h/%02h", wr_addr, wr_data, m_wr_addr, m_wr_data);
    end
    if (commit) begin
      checks++;
      if (rd_new !== b2) begin
        errors++; $display("FAIL rd_after_write @%02h: got %02h expected %02h", b1, rd_new, b2);
      end
      if (old_known) begin
        checks++;
        if (rd_old !== old_val) begin
          errors++; $display("FAIL rd_during_write @%02h: got %02h expected %02h", b1, rd_old, old_val);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; scl = 1'b1; sda_drv = 1'b1; rd_addr = 8'h00;
    cyc(6);
    checks++;
    if (wr_strobe !== 1'b0 || busy !== 1'b0 || siod !== 1'b1) begin
      errors++; $display("FAIL reset_ctrl: got stb=%b busy=%b siod=%b expected 0 0 1", wr_strobe, busy, siod);
    end
    checks++;
    if (wr_addr !== 8'h00 || wr_data !== 8'h00 || rd_data !== 8'h00) begin
      errors++; $display("FAIL reset_data: got %02h %02h %02h expected 00 00 00", wr_addr, wr_data, rd_data);
    end
    rst = 1'b0;
    cyc(4);
  endtask

  task automatic test_basic_write();
    xfer(DEV_ID, 8'h12, 8'h80, 8'h00, 3);
    rd_addr = 8'h12; cyc(1);
    checks++;
    if (rd_data !== 8'h80) begin
      errors++; $display("FAIL basic_read: got %02h expected 80", rd_data);
    end
    xfer(DEV_ID, 8'h12, 8'h81, 8'h00, 3);
  endtask

  task automatic test_id_mismatch();
    int d0;
    d0 = drive_cnt;
    xfer(8'h60, 8'h12, 8'h55, 8'h00, 3);
    checks++;
    if (drive_cnt != d0) begin
      errors++; $display("FAIL mismatch_drive: got %0d driven cycles expected 0", drive_cnt - d0);
    end
  endtask

  task automatic test_no_autoinc();
    xfer(DEV_ID, 8'h0A, 8'h00, 8'h00, 2);
    xfer(DEV_ID, 8'h0A, 8'h3C, 8'h99, 4);
    rd_addr = 8'h0A; cyc(1);
    checks++;
    if (rd_data !== 8'h3C) begin
      errors++; $display("FAIL no_autoinc: got %02h expected 3C", rd_data);
    end
  endtask

  task automatic test_repeated_start();
    logic [7:0] seq [5];
    bit acked;
    int stb0;
    xfer(DEV_ID, 8'h30, 8'hA5, 8'h00, 3);
    seq  = '{DEV_ID, 8'h30, DEV_ID, 8'h20, 8'h11};
    stb0 = stb_cnt;
    bus_start();
    for (int k = 0; k < 5; k++) begin
      if (k == 2) bus_start();
      send_bits(seq[k]);
      ack_slot(acked);
      checks++;
      if (acked !== 1'b1) begin
        errors++; $display("FAIL rstart_ack byte%0d: got %0d expected 1", k, acked);
      end
    end
    bus_stop();
    mref[8'h20] = 8'h11; known[8'h20] = 1'b1; m_wr_addr = 8'h20; m_wr_data = 8'h11;
    checks++;
    if ((stb_cnt - stb0) != 1 || wr_addr !== 8'h20 || wr_data !== 8'h11) begin
      errors++; $display("FAIL rstart_write: got n=%0d %02h/%02h expected n=1 20/11", stb_cnt - stb0, wr_addr, wr_data);
    end
    rd_addr = 8'h30; cyc(1);
    checks++;
    if (rd_data !== 8'hA5) begin
      errors++; $display("FAIL rstart_old_sub: got %02h expected A5", rd_data);
    end
    rd_addr = 8'h20; cyc(1);
    checks++;
    if (rd_data !== 8'h11) begin
      errors++; $display("FAIL rstart_new_sub: got %02h expected 11", rd_data);
    end
  endtask

  task automatic test_reset_mid();
    bit acked;
    bus_start();
    send_bits(DEV_ID); ack_slot(acked);
    send_bits(8'h55);  ack_slot(acked);
    send_bits(8'h77);
    cyc(4);
    checks++;
    if (siod !== 1'b0) begin
      errors++; $display("FAIL data_ack_drive: got %b expected 0", siod);
    end
    // value was committed on entry to the ACK slot
    mref[8'h55] = 8'h77; known[8'h55] = 1'b1;
    rst = 1'b1; cyc(1);
    checks++;
    if (siod !== 1'b1 || busy !== 1'b0 || wr_strobe !== 1'b0) begin
      errors++; $display("FAIL reset_mid_ctrl: got siod=%b busy=%b stb=%b expected 1 0 0", siod, busy, wr_strobe);
    end
    checks++;
    if (wr_addr !== 8'h00 || wr_data !== 8'h00 || rd_data !== 8'h00) begin
      errors++; $display("FAIL reset_mid_data: got %02h %02h %02h expected 00 00 00", wr_addr, wr_data, rd_data);
    end
    m_wr_addr = 8'h00; m_wr_data = 8'h00;
    cyc(3); rst = 1'b0;
    bus_stop();
    xfer(DEV_ID, 8'h66, 8'hE7, 8'h00, 3);
  endtask

  task automatic test_read_path();
    bit acked;
    logic [7:0] got;
    bus_start();
    send_bits(DEV_ID); ack_slot(acked);
    send_bits(8'h0A);  ack_slot(acked);
    bus_start();
    send_bits(DEV_ID | 8'h01);
    ack_slot(acked);
`ifdef SCCB_READ_EN
    checks++;
    if (acked !== 1'b1) begin
      errors++; $display("FAIL read_id_ack: got %0d expected 1", acked);
    end
    read_bits(got);
    checks++;
    if (got !== mref[8'h0A]) begin
      errors++; $display("FAIL read_byte: got %02h expected %02h", got, mref[8'h0A]);
    end
    ack_slot(acked);
`else
    checks++;
    if (acked !== 1'b0) begin
      errors++; $display("FAIL read_id_noack: got %0d expected 0", acked);
    end
    got = 8'h00;
`endif
    bus_stop();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL read_busy: got %b expected 0 (last %02h)", busy, got);
    end
  endtask

  task automatic test_random();
    logic [7:0] id;
    for (int t = 0; t < 24; t++) begin
      id = ($urandom_range(0, 3) == 0) ? 8'($urandom) : DEV_ID;
      if (id == (DEV_ID | 8'h01)) id = 8'h40;
      xfer(id, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(1, 4));
    end
  endtask

  task automatic test_readback();
    for (int a = 0; a < 256; a++) begin
      if (known[a]) begin
        rd_addr = 8'(a); cyc(1);
        checks++;
        if (rd_data !== mref[a]) begin
          errors++; $display("FAIL readback @%02h: got %02h expected %02h", a, rd_data, mref[a]);
        end
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      known[a] = 1'b0; mref[a] = 8'h00;
    end
    test_reset();
    test_basic_write();
    test_id_mismatch();
    test_no_autoinc();
    test_repeated_start();
    test_reset_mid();
    test_read_path();
    test_random();
    test_readback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sccb_target.md
# sccb_target

SCCB (I2C-style) responder that sits on the camera-side end of the SIOC/SIOD bus driven by the camera controller. It decodes three-phase write transactions (ID, subaddress, value), acknowledges them, and stores each value in a 256×8 register file. The host side of the design reads that file and sees every committed write as a pulse. The block serves as the camera model in simulation and as an on-FPGA bus monitor for checking configuration sequences.

## Interface
- DEVICE_ID, 8'h42, write ID to respond to; bit 0 must be 0; read ID is DEVICE_ID|1.
- GLOBAL_CLK  in  1  system clock; must be ≥ 16× SIOC frequency.
- RESET  in  1  synchronous, active-high reset.
- SIOC  in  1  SCCB serial clock from the initiator; asynchronous to GLOBAL_CLK.
- SIOD  inout  1  SCCB serial data, open-drain: either driven 0 or released to 'bz.
- WR_STROBE  out  1  one-cycle pulse on each committed write.
- WR_ADDR  out  8  subaddress of the last committed write.
- WR_DATA  out  8  value of the last committed write.
- RD_ADDR  in  8  host read address into the register file.
- RD_DATA  out  8  register file contents at RD_ADDR, registered.
- BUSY  out  1  high from a detected START until the matching STOP or abort.

## Operation
- Input conditioning: SIOC and SIOD each pass through a 2-flop synchronizer, then a history flop for edge detection.
- Bus events:
  - START: SIOD falls while SIOC is high.
  - STOP: SIOD rises while SIOC is high.
  - Bits are sampled on SIOC rising edges, MSB first.
- State machine: IDLE → ID → ID_ACK → SUB → SUB_ACK → DATA → DATA_ACK → WAIT_STOP. With SCCB_READ_EN there are also RD_BYTE and RD_NA.
- ID phase:
  - 8 bits equal to DEVICE_ID → ID_ACK.
  - Any other value → WAIT_STOP, with SIOD left released (no ACK).
- ACK slot: on the SIOC falling edge after the 8th bit, drive SIOD low. On the next SIOC falling edge (end of the 9th clock), release SIOD.
- SUB phase: received byte goes into the 8-bit pointer register (PTR).
- DATA phase:
  - The byte is written to mem[PTR] in the cycle DATA_ACK is entered.
  - WR_STROBE pulses in the same cycle; WR_ADDR/WR_DATA update in the same cycle and hold until the next write.
- After DATA_ACK the FSM goes to WAIT_STOP. Further bytes are not acked and not stored (no auto-increment).
- Boundary and abort rules:
  - STOP in any state → IDLE. A transaction stopped before DATA_ACK commits nothing; PTR keeps any completed subaddress.
  - START in any state (repeated start) → ID, bit counter cleared, SIOD released.
  - WR_STROBE and a host read of the same address in the same cycle: RD_DATA returns the old value; the new value appears from the next read.
- Host read: RD_DATA <= mem[RD_ADDR] every cycle. The file maps to EBR.

## Timing
- SIOC/SIOD edges are detected 3 GLOBAL_CLK cycles after the pin transition.
- SIOD is pulled low ≤ 4 cycles after the SIOC falling edge, well inside the SCCB low period.
- WR_STROBE fires 3–4 cycles after the 8th data bit's SIOC rising edge.
- RD_DATA latency is 1 cycle from RD_ADDR.
- Reset values:
  - FSM = IDLE, SIOD released, PTR = 0.
  - WR_STROBE = 0, WR_ADDR = 0, WR_DATA = 0, RD_DATA = 0, BUSY = 0.
  - Memory contents are not cleared.
- RESET mid-transaction: SIOD is released on the next clock edge; the FSM ignores the bus until the next START.

## Configuration
- SCCB_READ_EN defined:
  - The read ID (DEVICE_ID|1) is acked and the FSM goes to RD_BYTE.
  - RD_BYTE shifts mem[PTR] out MSB first, changing SIOD on SIOC falling edges and driving 0 bits low.
  - After 8 bits, RD_NA releases SIOD; the initiator's NA is ignored; then WAIT_STOP.
- SCCB_READ_EN undefined: the read ID is treated as a mismatch (no ACK, WAIT_STOP), and no read logic is synthesized.

## Test plan
- Write 0x42, 0x12, 0x80 then STOP → SIOD low in all 3 ACK slots; exactly one WR_STROBE with WR_ADDR = 0x12, WR_DATA = 0x80; RD_ADDR = 0x12 gives RD_DATA = 0x80 one cycle later.
- ID 0x60, 0x12, 0x55 → SIOD never driven, no WR_STROBE, BUSY drops at STOP.
- Write 0x42, 0x0A, then STOP → no strobe. Then write 0x42, 0x0A, 0x3C, 0x99 → only 0x3C is stored at 0x0A; the 4th byte is not acked.
- Repeated START after the subaddress, then 0x42, 0x20, 0x11 → stored at 0x20; nothing is written at the earlier subaddress.
- RESET asserted mid-DATA phase while SIOD is low → SIOD released the next cycle, all outputs at reset values; the next full transaction works normally.
- Read path: with SCCB_READ_EN, write 0x42, 0x0A then 0x43 → SIOD returns 0x3C MSB first. Without SCCB_READ_EN, 0x43 is not acked.
